// File: rtl/gmii_rx_packer.sv
// GMII receive stream to 18-bit tagged FIFO words with a timestamp/flags prefix.
// Optional macro RXER_TRUNCATE_EN: gmii_rx_er during a frame truncates it like a queue overflow.
module gmii_rx_packer #(
  parameter logic        PORT_ID = 1'b0,
  parameter int unsigned QDEPTH  = 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        gmii_rx_dv,
  input  logic        gmii_rx_er,
  input  logic [7:0]  gmii_rxd,
  input  logic [63:0] global_counter,
  output logic [17:0] fifo_din,
  output logic        fifo_wr_en,
  input  logic        fifo_full,
  output logic [7:0]  rx_count,
  output logic [15:0] drop_count
);

  localparam int unsigned AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [1:0] TAG_MID   = 2'b11;
  localparam logic [1:0] TAG_LAST2 = 2'b01;
  localparam logic [1:0] TAG_LAST1 = 2'b10;
  localparam logic [1:0] TAG_TERM  = 2'b00;

  typedef enum logic [2:0] {IDLE, PRE, HDR, DATA, FLUSH, DROP, TERM} state_t;

  state_t        state_q, state_d;
  logic [63:0]   ts_q, ts_d;
  logic [2:0]    hdr_cnt_q, hdr_cnt_d;
  logic [1:0]    flags_tag_q, flags_tag_d;
  logic [7:0]    byte_q, byte_d;
  logic          odd_q, odd_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] qcnt_q, qcnt_d;
  logic [7:0]    rx_count_q, rx_count_d;
  logic [15:0]   drop_count_q, drop_count_d;
  logic [17:0]   q_mem [QDEPTH];

  logic          rx_err_c, active_c, receiving_c;
  logic          push_c, pop_c, retag_c, wr_c, hdr_wr_c, drop_inc_c;
  logic [17:0]   push_word_c, out_word_c;

`ifdef RXER_TRUNCATE_EN
  assign rx_err_c = gmii_rx_er;
`else
  logic unused_rx_er;
  assign unused_rx_er = gmii_rx_er;
  assign rx_err_c     = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    ts_d         = ts_q;
    hdr_cnt_d    = hdr_cnt_q;
    flags_tag_d  = flags_tag_q;
    byte_d       = byte_q;
    odd_d        = odd_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    qcnt_d       = qcnt_q;
    rx_count_d   = rx_count_q;
    drop_count_d = drop_count_q;
    push_c       = 1'b0;
    push_word_c  = '0;
    pop_c        = 1'b0;
    retag_c      = 1'b0;
    wr_c         = 1'b0;
    hdr_wr_c     = 1'b0;
    drop_inc_c   = 1'b0;
    out_word_c   = '0;
    active_c     = state_q inside {HDR, DATA, FLUSH, TERM};
    receiving_c  = state_q inside {HDR, DATA};

    // Output source: header words first, then queue, then the terminator.
    // While the frame is still arriving the newest word is held back for retagging.
    if (active_c && hdr_cnt_q < 3'd5) begin
      hdr_wr_c = !fifo_full && (hdr_cnt_q != 3'd4 || !receiving_c || qcnt_q != '0);
      case (hdr_cnt_q)
        3'd0:    out_word_c = {TAG_MID, ts_q[63:48]};
        3'd1:    out_word_c = {TAG_MID, ts_q[47:32]};
        3'd2:    out_word_c = {TAG_MID, ts_q[31:16]};
        3'd3:    out_word_c = {TAG_MID, ts_q[15:0]};
        default: out_word_c = {flags_tag_q, 15'h0, PORT_ID};
      endcase
      wr_c = hdr_wr_c;
    end else if (active_c && qcnt_q != '0) begin
      pop_c      = !fifo_full && (!receiving_c || qcnt_q >= CW'(2));
      out_word_c = q_mem[rptr_q];
      wr_c       = pop_c;
    end else if (state_q == TERM) begin
      out_word_c = {TAG_TERM, 16'h0};
      wr_c       = !fifo_full;
    end

    case (state_q)
      IDLE: if (gmii_rx_dv) state_d = PRE;
      PRE: begin
        if (!gmii_rx_dv) begin
          state_d = IDLE;
        end else if (gmii_rxd == 8'hD5) begin
          if (fifo_full) begin
            state_d    = DROP;
            drop_inc_c = 1'b1;
          end else begin
            state_d     = HDR;
            ts_d        = global_counter;
            hdr_cnt_d   = 3'd0;
            flags_tag_d = TAG_MID;
            odd_d       = 1'b0;
          end
        end else if (gmii_rxd != 8'h55) begin
          state_d = DROP;
        end
      end
      HDR, DATA: begin
        if (state_q == HDR && hdr_wr_c && hdr_cnt_q == 3'd4) state_d = DATA;
        if (gmii_rx_dv && rx_err_c) begin
          state_d = TERM;
          odd_d   = 1'b0;
        end else if (gmii_rx_dv) begin
          if (!odd_q) begin
            byte_d = gmii_rxd;
            odd_d  = 1'b1;
          end else begin
            push_c      = 1'b1;
            push_word_c = {TAG_MID, byte_q, gmii_rxd};
            odd_d       = 1'b0;
          end
        end else begin
          state_d = FLUSH;
          if (odd_q) begin
            push_c      = 1'b1;
            push_word_c = {TAG_LAST1, byte_q, 8'h00};
            odd_d       = 1'b0;
          end else if (qcnt_q != '0) begin
            retag_c = 1'b1;
          end else begin
            flags_tag_d = TAG_LAST2;
          end
        end
        // Pushing onto a full queue truncates the frame.
        if (push_c && qcnt_q == CW'(QDEPTH) && !pop_c) begin
          push_c  = 1'b0;
          odd_d   = 1'b0;
          state_d = TERM;
        end
      end
      FLUSH: begin
        if (wr_c && out_word_c[17:16] != TAG_MID) state_d = IDLE;
        else if (hdr_cnt_q == 3'd5 && qcnt_q == '0) state_d = IDLE;
      end
      TERM: if (wr_c && out_word_c[17:16] == TAG_TERM) state_d = gmii_rx_dv ? DROP : IDLE;
      DROP: if (!gmii_rx_dv) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (hdr_wr_c) hdr_cnt_d = hdr_cnt_q + 3'd1;
    if (push_c) wptr_d = wptr_q + AW'(1);
    if (pop_c) rptr_d = rptr_q + AW'(1);
    qcnt_d = qcnt_q + CW'(push_c) - CW'(pop_c);
    if (wr_c && out_word_c[17:16] != TAG_MID) rx_count_d = rx_count_q + 8'd1;
    if (wr_c && out_word_c[17:16] == TAG_TERM) drop_inc_c = 1'b1;
    if (drop_inc_c && drop_count_q != 16'hFFFF) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= IDLE;
      ts_q         <= '0;
      hdr_cnt_q    <= '0;
      flags_tag_q  <= TAG_MID;
      byte_q       <= '0;
      odd_q        <= 1'b0;
      wptr_q       <= '0;
      rptr_q       <= '0;
      qcnt_q       <= '0;
      rx_count_q   <= '0;
      drop_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ts_q         <= ts_d;
      hdr_cnt_q    <= hdr_cnt_d;
      flags_tag_q  <= flags_tag_d;
      byte_q       <= byte_d;
      odd_q        <= odd_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      qcnt_q       <= qcnt_d;
      rx_count_q   <= rx_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Queue storage; validity is tracked by the pointers and count.
  always_ff @(posedge sys_clk) begin
    if (push_c) q_mem[wptr_q] <= push_word_c;
    if (retag_c) q_mem[wptr_q - AW'(1)][17:16] <= TAG_LAST2;
  end

  // The write strobe follows fifo_full in the same cycle so no write lands on a full FIFO.
  assign fifo_wr_en = wr_c;
  assign fifo_din   = wr_c ? out_word_c : 18'h0;
  assign rx_count   = rx_count_q;
  assign drop_count = drop_count_q;

endmodule

// File: doc/gmii_rx_packer.md
Name: gmii_rx_packer

Overview:
- Upstream feeder of the DMA receive engine: converts one GMII receive stream into the 18-bit PHY FIFO word stream that the engine drains.
- Strips preamble/SFD, prepends a 10-byte prefix (8-byte global-counter timestamp plus 2-byte flags), and packs bytes into 16-bit words with frame/length tags.
- Bumps an 8-bit frame counter when a frame is fully written.
- One instance per PHY. Sits in front of a dual-clock FIFO; sys_clk is the PHY 125 MHz receive clock.

Parameters:
- PORT_ID, 1'b0, PHY number placed in flags word bit 0
- QDEPTH, 4, data-word skid queue depth (power of 2, >=2)

Ports:
- sys_clk  in  1  PHY receive clock, 125 MHz
- sys_rst  in  1  asynchronous reset, active high
- gmii_rx_dv  in  1  GMII data valid
- gmii_rx_er  in  1  GMII receive error
- gmii_rxd  in  8  GMII receive byte
- global_counter  in  64  free-running timestamp, same clock domain
- fifo_din  out  18  FIFO word: [17:16] tag, [15:8] first byte, [7:0] second byte
- fifo_wr_en  out  1  FIFO write strobe
- fifo_full  in  1  FIFO full; no write is issued while high
- rx_count  out  8  frames fully committed, wraps at 255->0
- drop_count  out  16  frames dropped or truncated, saturates at 16'hFFFF

Behaviour:
- Reset: fifo_din=0, fifo_wr_en=0, rx_count=0, drop_count=0, queue empty, state IDLE.
- Tags: 11=middle word, 2 bytes; 01=last word, 2 bytes; 10=last word, 1 byte (in [15:8], [7:0]=0); 00=truncation terminator, data 0.
- States:
  - IDLE: dv=1 -> PRE.
  - PRE: dv=0 -> IDLE with no writes. rxd=55 -> stay. rxd=D5 with fifo_full=0 -> HDR; sample global_counter this cycle. rxd=D5 with fifo_full=1 -> DROP, drop_count+1. Any other byte -> DROP, no count.
  - HDR: write prefix words on the 5 cycles after SFD, one per cycle, stalling while fifo_full: ts[63:48], ts[47:32], ts[31:16], ts[15:0], {15'h0, PORT_ID}. Bytes arriving meanwhile pack into the queue. Then DATA.
  - DATA: bytes pair first->[15:8], second->[7:0]; each complete pair is pushed to the queue tagged 11. The queue head is written when fifo_full=0.
  - DROP: no writes until dv=0, then IDLE.
  - TERM: pending 00 write, issued as soon as fifo_full=0, then IDLE.
- Hold-back rule: the newest word (header or data) is never written until a later word exists or the frame has ended. This lets it be retagged as the last word.
- Frame end (dv falls):
  - Odd byte pending: push it tagged 10.
  - Otherwise: retag the held word 01.
  - Zero payload bytes: the flags word goes out tagged 01.
- After the last tagged word is written: rx_count+1 in the same cycle as that fifo_wr_en. State returns to IDLE once the queue is drained.
- Truncation: a push onto a full queue discards the frame remainder. Queued words still drain, then one 00 terminator is written. drop_count+1, rx_count+1 on the terminator write. State -> TERM until dv=0 and the terminator is written.
- dv re-asserting before drain completes: bytes are ignored until IDLE; no new frame starts.
- Throughput: worst-case word rate 0.5/cycle, so QDEPTH=4 never overflows with fifo_full=0.
- rx_count wrap 255->0 is legal; the consumer compares for inequality.
- Reset mid-frame clears everything; the partial frame is lost and no terminator is written.

Optional Feature:
- Macro: RXER_TRUNCATE_EN.
- Defined: gmii_rx_er=1 with dv=1 in HDR/DATA is treated exactly as truncation (00 terminator, drop_count+1, rx_count+1).
- Undefined: gmii_rx_er is ignored and bytes are stored as received.

Test Plan:
- 7x55, D5, 60 bytes 00..3B, fifo_full=0, global_counter=0x0011223344556677:
  - 5 header words 0011,2233,4455,6677,0000 tagged 11.
  - Then 29 words 0001..3839 tagged 11, then 3A3B tagged 01.
  - rx_count 0->1 on the last write.
- 61-byte frame: last word {10, 3C00}. Zero-byte frame (dv falls after SFD): flags word tagged 01.
- fifo_full=1 held 20 cycles mid-payload of a 60-byte frame:
  - Queue overflows; queued words drain, then {00,0000}.
  - drop_count=1, rx_count=1.
- fifo_full=1 at SFD: no writes, drop_count=1, rx_count unchanged. Preamble with a byte 0x5A: no writes, no counts.
- With RXER_TRUNCATE_EN, rx_er pulse on byte 10: terminator written after byte-9 word, drop_count+1. Without the macro: full 60-byte frame stored.
- 256 back-to-back 64-byte frames with 12-byte IPG: rx_count wraps to 0, drop_count=0, no fifo_wr_en while fifo_full.
